// File: rtl/pseudo_rand_num_gen_pkg.sv
// Shared types and constants for the pseudo-random pattern generator.
package pseudo_rand_num_gen_pkg;

    // Sequencer states shared by the generator and anything that observes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pg_state_e;

    // Galois right-shift feedback mask for x^64 + x^63 + x^61 + x^60 + 1.
    // Bit k of the mask corresponds to the x^(k+1) term.
    localparam logic [63:0] DEFAULT_TAPS = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/pattern_generator_lfsr.sv
// Galois LFSR, right-shifting, with synchronous load and step enable.
// Load takes priority over enable. Reset clears the register to zero.
module lfsr #(
    parameter int                  NUM_BITS = 64,
    parameter logic [NUM_BITS-1:0] TAPS     = NUM_BITS'(pseudo_rand_num_gen_pkg::DEFAULT_TAPS)
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_value,
    input  logic                enable,
    output logic [NUM_BITS-1:0] state
);

    logic [NUM_BITS-1:0] state_q;
    logic [NUM_BITS-1:0] step_value;

    assign step_value = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);

    // Shift register: load a new value, step once, or hold.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= '0;
        end else if (load) begin
            state_q <= load_value;
        end else if (enable) begin
            state_q <= step_value;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/pattern_generator.sv
// Pattern generator: issues num_patterns_i LFSR patterns over a valid/ready
// handshake, then pulses stop_o once and parks in DONE until restarted.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | after reset; waiting for start_i
//   RUN   | valid_o high; each accepted pattern decrements the count
//   DONE  | run finished (or started with zero patterns); waits for start_i
//
// The remaining-pattern count is a down-counter; the run ends on the
// transfer seen while the count equals one, so it can never wrap.
module pattern_generator
    import pseudo_rand_num_gen_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    COUNT_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] TAPS        = DATA_WIDTH'(DEFAULT_TAPS)
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   start_i,
    input  logic                   bypass_i,
    input  logic [DATA_WIDTH-1:0]  seed_i,
    input  logic [COUNT_WIDTH-1:0] num_patterns_i,
    input  logic                   dut_ready_i,
    output logic                   valid_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   stop_o,
    output logic                   busy_o
);

    pg_state_e              state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   stop_q, stop_d;
    logic                   lfsr_load;
    logic                   lfsr_enable;
    logic [DATA_WIDTH-1:0]  lfsr_load_value;
    logic [DATA_WIDTH-1:0]  lfsr_state;

    // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
    assign lfsr_load_value = (seed_i == '0) ? '1 : seed_i;

    // State, count and stop-pulse registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            count_q <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            stop_q  <= stop_d;
        end
    end

    // Next-state, count update and LFSR control.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        stop_d      = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_enable = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    if (num_patterns_i != '0) begin
                        state_d   = RUN;
                        count_d   = num_patterns_i;
                        lfsr_load = 1'b1;
                    end else begin
                        state_d = DONE;
                        stop_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                // start_i is deliberately ignored here; only transfers matter.
                if (dut_ready_i) begin
                    count_d     = count_q - COUNT_WIDTH'(1);
                    lfsr_enable = ~bypass_i;
                    if (count_q == COUNT_WIDTH'(1)) begin
                        state_d = DONE;
                        stop_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    lfsr #(
        .NUM_BITS (DATA_WIDTH),
        .TAPS     (TAPS)
    ) u_lfsr (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load       (lfsr_load),
        .load_value (lfsr_load_value),
        .enable     (lfsr_enable),
        .state      (lfsr_state)
    );

    // Outputs decode registered state only; dut_ready_i never reaches them.
    assign valid_o = (state_q == RUN);
    assign busy_o  = (state_q == RUN);
    assign stop_o  = stop_q;
    assign data_o  = lfsr_state;

endmodule

// File: tb/tb_pattern_generator.sv
// Bench for pattern_generator (8-bit, taps 8'hB8): directed scenarios plus
// randomized runs checked cycle by cycle against a transaction-level model.
module tb_pattern_generator;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam logic [DW-1:0] TB_TAPS = 8'hB8;

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          start_i;
    logic          bypass_i;
    logic [DW-1:0] seed_i;
    logic [CW-1:0] num_patterns_i;
    logic          dut_ready_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic          stop_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    pattern_generator #(
        .DATA_WIDTH  (DW),
        .COUNT_WIDTH (CW),
        .TAPS        (TB_TAPS)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .start_i        (start_i),
        .bypass_i       (bypass_i),
        .seed_i         (seed_i),
        .num_patterns_i (num_patterns_i),
        .dut_ready_i    (dut_ready_i),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .stop_o         (stop_o),
        .busy_o         (busy_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: is a run in progress, how many patterns remain, which
    // pattern is on offer, and whether a stop pulse is due this cycle.
    bit          m_run  = 1'b0;
    int          m_left = 0;
    logic [7:0]  m_pat  = '0;
    bit          m_stop = 1'b0;

    // Patterns the DUT actually handed over during the current run.
    logic [7:0]  dut_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] ref_step(input logic [7:0] s);
        return (s / 2) ^ (((s % 2) == 1) ? TB_TAPS : 8'h00);
    endfunction

    // Advance one clock; record handshakes, update the model, compare outputs.
    task automatic tick(input string tag);
        @(negedge clk_i);
        if (valid_o === 1'b1 && dut_ready_i) dut_q.push_back(data_o);
        @(posedge clk_i);
        m_stop = 1'b0;
        if (m_run) begin
            if (dut_ready_i) begin
                if (!bypass_i) m_pat = ref_step(m_pat);
                m_left--;
                if (m_left == 0) begin
                    m_run  = 1'b0;
                    m_stop = 1'b1;
                end
            end
        end else if (start_i) begin
            if (num_patterns_i != 0) begin
                m_run  = 1'b1;
                m_pat  = (seed_i == 0) ? 8'hFF : seed_i;
                m_left = int'(num_patterns_i);
            end else begin
                m_stop = 1'b1;
            end
        end
        #1;
        check({tag, ".valid"}, 64'(valid_o), 64'(m_run));
        check({tag, ".busy"},  64'(busy_o),  64'(m_run));
        check({tag, ".stop"},  64'(stop_o),  64'(m_stop));
        if (m_run) check({tag, ".data"}, 64'(data_o), 64'(m_pat));
    endtask

    task automatic run(input logic [7:0] seed, input logic [7:0] n, input int ready_pct,
                       input int byp_pct, input int hold_low, input string tag);
        dut_q.delete();
        start_i        = 1'b1;
        seed_i         = seed;
        num_patterns_i = n;
        bypass_i       = ($urandom_range(99) < byp_pct);
        dut_ready_i    = $urandom_range(1) == 1;
        tick(tag);
        start_i = 1'b0;
        for (int c = 0; c < 400 && (m_run || stop_o === 1'b1); c++) begin
            seed_i         = 8'($urandom);
            num_patterns_i = 8'($urandom);
            start_i        = (m_run && m_left > 1) ? ($urandom_range(2) == 0) : 1'b0;
            bypass_i       = ($urandom_range(99) < byp_pct);
            if (c < hold_low)  dut_ready_i = 1'b0;
            else if (c > 200)  dut_ready_i = 1'b1;
            else               dut_ready_i = ($urandom_range(99) < ready_pct);
            tick(tag);
        end
        start_i = 1'b0;
        check({tag, ".xfers"}, 64'(dut_q.size()), 64'(n));
        check({tag, ".end_busy"}, 64'(busy_o), 64'h0);
    endtask

    // Compare the recorded transfers against up to eight expected bytes,
    // packed most-significant first.
    task automatic check_q(input string tag, input int n, input logic [63:0] packed_exp);
        logic [7:0] e;
        logic [7:0] o;
        for (int i = 0; i < n; i++) begin
            e = packed_exp[63 - 8*i -: 8];
            o = (i < dut_q.size()) ? dut_q[i] : 8'hxx;
            check($sformatf("%s.seq%0d", tag, i), 64'(o), 64'(e));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".valid"}, 64'(valid_o), 64'h0);
        check({tag, ".busy"},  64'(busy_o),  64'h0);
        check({tag, ".stop"},  64'(stop_o),  64'h0);
        check({tag, ".data"},  64'(data_o),  64'h0);
    endtask

    initial begin
        rstn_i         = 1'b0;
        start_i        = 1'b0;
        bypass_i       = 1'b0;
        seed_i         = '0;
        num_patterns_i = '0;
        dut_ready_i    = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1;

        // Idle with ready toggling: nothing may happen.
        for (int i = 0; i < 3; i++) begin
            dut_ready_i = $urandom_range(1) == 1;
            tick("idle");
        end

        run(8'h01, 8'd4, 100, 0, 0, "seq4");
        check_q("seq4", 4, 64'h01B8_5C2E_0000_0000);

        run(8'h01, 8'd2, 100, 0, 3, "stall");
        check_q("stall", 2, 64'h01B8_0000_0000_0000);

        run(8'h00, 8'd1, 100, 0, 0, "zseed");
        check_q("zseed", 1, 64'hFF00_0000_0000_0000);

        run(8'h77, 8'd0, 100, 0, 0, "zero_n");

        run(8'h5A, 8'd3, 100, 100, 0, "bypass");
        check_q("bypass", 3, 64'h5A5A_5A00_0000_0000);

        // Abort a 5-pattern run after two transfers.
        dut_q.delete();
        start_i        = 1'b1;
        seed_i         = 8'h01;
        num_patterns_i = 8'd5;
        bypass_i       = 1'b0;
        dut_ready_i    = 1'b1;
        tick("abort");
        start_i = 1'b0;
        tick("abort");
        tick("abort");
        check("abort.xfers", 64'(dut_q.size()), 64'd2);
        dut_ready_i = 1'b0;
        #2;
        rstn_i = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_run  = 1'b0;
        m_stop = 1'b0;
        @(posedge clk_i);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dut_ready_i = $urandom_range(1) == 1;
            tick("post_rst");
        end
        run(8'h01, 8'd5, 100, 0, 0, "restart");
        check_q("restart", 5, 64'h01B8_5C2E_1700_0000);

        for (int r = 0; r < 12; r++) begin
            run(8'($urandom), 8'($urandom_range(12)), int'($urandom_range(100, 30)),
                int'($urandom_range(50)), 0, $sformatf("rnd%0d", r));
            for (int i = 0; i < int'($urandom_range(3)); i++) begin
                dut_ready_i = $urandom_range(1) == 1;
                tick($sformatf("gap%0d", r));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pattern_generator.md
PATTERN_GENERATOR -- requirements
Module: pattern_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 64, pattern width in bits.
REQ-002 Parameter COUNT_WIDTH, default 16, width of the pattern-count field.
REQ-003 Parameter TAPS, DATA_WIDTH bits, default from package, Galois LFSR feedback mask.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rstn_i  input  1  asynchronous, active-low reset.
REQ-006 start_i  input  1  begin a test run; sampled in IDLE and DONE.
REQ-007 bypass_i  input  1  hold LFSR; data_o repeats the loaded seed.
REQ-008 seed_i  input  DATA_WIDTH  initial LFSR value, captured on start.
REQ-009 num_patterns_i  input  COUNT_WIDTH  patterns to issue, captured on start.
REQ-010 dut_ready_i  input  1  DUT accepts data_o this cycle.
REQ-011 valid_o  output  1  data_o holds a valid pattern.
REQ-012 data_o  output  DATA_WIDTH  current pattern (LFSR state).
REQ-013 stop_o  output  1  one-cycle pulse after the last pattern; drives the signature analyzer stop input.
REQ-014 busy_o  output  1  high while in RUN.

Function
REQ-015 FSM states IDLE, RUN, DONE use the shared state enum.
REQ-016 IDLE/DONE with start_i=1 and num_patterns_i!=0 -> RUN next cycle; LFSR<=seed, count<=num_patterns_i.
REQ-017 Zero-seed rule: seed_i==0 loads all-ones to avoid LFSR lockup.
REQ-018 IDLE/DONE with start_i=1 and num_patterns_i==0 -> DONE; stop_o pulses 1 cycle; valid_o never asserts.
REQ-019 In RUN: valid_o=1, busy_o=1, data_o=LFSR state.
REQ-020 Handshake: transfer when valid_o&dut_ready_i; valid_o stays high and data_o stable until transfer.
REQ-021 On transfer: count decrements; LFSR advances unless bypass_i=1.
REQ-022 LFSR step (Galois, right shift): next = (state>>1) XOR (state[0] ? TAPS : 0).
REQ-023 Transfer with count==1 -> DONE next cycle; stop_o=1 for exactly that first DONE cycle.
REQ-024 DONE is sticky: valid_o=0, busy_o=0, data_o holds last LFSR value; leaves only via start_i.
REQ-025 start_i in RUN is ignored.
REQ-026 dut_ready_i outside RUN is ignored.
REQ-027 bypass_i is sampled every cycle; toggling mid-run only gates LFSR advance, never the count.
REQ-028 Exactly num_patterns_i transfers occur per run; the count never wraps.

Reset
REQ-029 rstn_i low -> state=IDLE, LFSR=0, count=0, valid_o=0, stop_o=0, busy_o=0, data_o=0, all immediately (asynchronous).
REQ-030 Reset mid-RUN aborts the run with no stop_o pulse; after release the block waits in IDLE for start_i.

Structure
REQ-031 Package pseudo_rand_num_gen_pkg holds the state enum (IDLE/RUN/DONE) and the default TAPS constant (64-bit: x^64+x^63+x^61+x^60+1).
REQ-032 One sub-module, lfsr (parameters NUM_BITS, TAPS; ports load, load value, enable, state), instantiated once.
REQ-033 FSM and counter live in pattern_generator; stop_o and valid_o are registered or decoded from registered state only, with no combinational path from dut_ready_i.

Verification (DATA_WIDTH=8, TAPS=8'hB8)
REQ-034 Seed 8'h01, N=4, dut_ready_i held 1 -> data_o sequence 01, B8, 5C, 2E over 4 cycles; then stop_o pulses once; busy_o falls.
REQ-035 Seed 8'h01, N=2, dut_ready_i low for 3 cycles -> data_o stays 01 with valid_o high; after ready rises, B8 is transferred; then stop_o.
REQ-036 Seed 8'h00, N=1 -> data_o=FF; then stop_o.
REQ-037 num_patterns_i=0 with start -> no valid_o; stop_o pulses in the following cycle; state=DONE.
REQ-038 bypass_i=1, seed 8'h5A, N=3 -> 3 transfers, all 5A; then stop_o.
REQ-039 rstn_i asserted after 2 of 5 transfers -> all outputs 0 asynchronously; no stop_o; a new start restarts cleanly from seed.
